// File: rtl/mod_fifo_pkg.sv
// Shared sizing helpers and default parameters for the multi-channel elastic buffer.
package mod_fifo_pkg;

   localparam int DEF_WIDTH    = 8;
   localparam int DEF_CHANNELS = 4;
   localparam int DEF_DEPTH    = 4;

   // Occupancy counter width: must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Circular-buffer pointer width: indexes 0..depth-1.
   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/mod_fifo_ram.sv
// Entry storage for the elastic buffer: one synchronous write port, one
// asynchronous read port. No reset, so contents are undefined until written.
module mod_fifo_ram
   import mod_fifo_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int CHANNELS = DEF_CHANNELS,
   parameter int DEPTH    = DEF_DEPTH
) (
   input  logic                           clk,
   input  logic                           i_wr_en,
   input  logic [ptr_w(DEPTH)-1:0]        i_wr_addr,
   input  logic signed [WIDTH-1:0]        i_wr_data [CHANNELS],
   input  logic [ptr_w(DEPTH)-1:0]        i_rd_addr,
   output logic signed [WIDTH-1:0]        o_rd_data [CHANNELS]
);

   logic signed [WIDTH-1:0] r_mem [DEPTH][CHANNELS];

   // Whole-entry write; all channels of one entry land together.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mod_fifo_param.sv
// Parametrised multi-channel elastic buffer with valid/ready on both sides and
// an optional drop-oldest overwrite mode. Storage lives in mod_fifo_ram; this
// level holds only pointers, occupancy, flags and handshake.
module mod_fifo_param
   import mod_fifo_pkg::*;
#(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               CHANNELS  = DEF_CHANNELS,
   parameter int               DEPTH     = DEF_DEPTH,
   parameter bit               OVERWRITE = 1'b0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [WIDTH-1:0]   data_in [CHANNELS],
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [WIDTH-1:0]   data_out [CHANNELS],
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      full,
   output logic                      empty,
   output logic                      overrun
);

   localparam int               PTR_W    = ptr_w(DEPTH);
   localparam int               CNT_W    = cnt_w(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic                    r_full;
   logic                    r_empty;
   logic                    r_overrun;

   logic [PTR_W-1:0]        w_wr_ptr_nxt;
   logic [PTR_W-1:0]        w_rd_ptr_nxt;
   logic [CNT_W-1:0]        w_count_nxt;
   logic                    w_overrun_nxt;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_drop;
   logic signed [WIDTH-1:0] w_rd_data [CHANNELS];

   // In back-pressure mode in_ready comes straight from the full register, so
   // there is no combinational path from out_ready to in_ready.
   if (OVERWRITE) begin : g_ready_ovw
      assign in_ready = 1'b1;
   end else begin : g_ready_bp
      assign in_ready = !r_full;
   end

   assign out_valid = !r_empty;
   assign w_push    = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   // Push into a full buffer without a pop: only reachable in overwrite mode.
   assign w_drop    = w_push && !w_pop && r_full;

   // Next pointer/occupancy; a drop advances the read pointer past the oldest entry.
   always_comb begin
      w_wr_ptr_nxt  = r_wr_ptr;
      w_rd_ptr_nxt  = r_rd_ptr;
      w_count_nxt   = r_count;
      w_overrun_nxt = r_overrun;
      if (w_push) begin
         w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop || w_drop) begin
         w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop && !w_drop) begin
         w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - CNT_W'(1);
      end
      if (w_drop) begin
         w_overrun_nxt = 1'b1;
      end
   end

   // State registers; flags are derived from the next count so they move on
   // the same edge as the pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_overrun <= 1'b0;
      end else if (flush) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_full    <= 1'b0;
         r_empty   <= 1'b1;
         r_overrun <= 1'b0;
      end else begin
         r_wr_ptr  <= w_wr_ptr_nxt;
         r_rd_ptr  <= w_rd_ptr_nxt;
         r_count   <= w_count_nxt;
         r_full    <= (w_count_nxt == CNT_FULL);
         r_empty   <= (w_count_nxt == '0);
         r_overrun <= w_overrun_nxt;
      end
   end

   mod_fifo_ram #(
      .WIDTH    (WIDTH),
      .CHANNELS (CHANNELS),
      .DEPTH    (DEPTH)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_push && !flush),
      .i_wr_addr (r_wr_ptr),
      .i_wr_data (data_in),
      .i_rd_addr (r_rd_ptr),
      .o_rd_data (w_rd_data)
   );

   // Head entry when occupied, the reset pattern on every channel when empty.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         data_out[c] = r_empty ? RESET_VAL : w_rd_data[c];
      end
   end

   assign count   = r_count;
   assign full    = r_full;
   assign empty   = r_empty;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_mod_fifo_param.sv
// Bench for mod_fifo_param: instance A is back-pressure mode (RESET_VAL 8'h5A),
// instance B is overwrite mode (RESET_VAL 0). Both are tracked by a queue model.
module tb_mod_fifo_param;

   localparam int W = 8;
   localparam int C = 4;
   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic a_flush = 0, a_in_valid = 0, a_out_ready = 0;
   logic a_in_ready, a_out_valid, a_full, a_empty, a_overrun;
   logic signed [W-1:0] a_din [C];
   logic signed [W-1:0] a_dout [C];
   logic [2:0] a_count;

   logic b_flush = 0, b_in_valid = 0, b_out_ready = 0;
   logic b_in_ready, b_out_valid, b_full, b_empty, b_overrun;
   logic signed [W-1:0] b_din [C];
   logic signed [W-1:0] b_dout [C];
   logic [2:0] b_count;

   int n_cmp = 0;
   int n_err = 0;

   mod_fifo_param #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .OVERWRITE(1'b0), .RESET_VAL(8'h5A)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .data_in(a_din), .out_valid(a_out_valid), .out_ready(a_out_ready), .data_out(a_dout),
      .count(a_count), .full(a_full), .empty(a_empty), .overrun(a_overrun));

   mod_fifo_param #(.WIDTH(W), .CHANNELS(C), .DEPTH(D), .OVERWRITE(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .data_in(b_din), .out_valid(b_out_valid), .out_ready(b_out_ready), .data_out(b_dout),
      .count(b_count), .full(b_full), .empty(b_empty), .overrun(b_overrun));

   // ---------------- reference model: entries packed as 4 x 8 bits ----------------
   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic        ov_b = 1'b0;
   logic [31:0] m_ea, m_eb;

   always @(posedge clk) begin
      if (rst_n) begin
         for (int c = 0; c < C; c++) begin
            m_ea[8*c +: 8] = a_din[c];
            m_eb[8*c +: 8] = b_din[c];
         end
         if (a_flush) begin
            q_a.delete();
         end else begin
            automatic bit push = a_in_valid && (q_a.size() < D);
            automatic bit pop  = a_out_ready && (q_a.size() > 0);
            if (pop) void'(q_a.pop_front());
            if (push) q_a.push_back(m_ea);
         end
         if (b_flush) begin
            q_b.delete();
            ov_b = 1'b0;
         end else begin
            if (b_out_ready && (q_b.size() > 0)) void'(q_b.pop_front());
            if (b_in_valid) begin
               if (q_b.size() == D) begin
                  void'(q_b.pop_front());
                  ov_b = 1'b1;
               end
               q_b.push_back(m_eb);
            end
         end
      end
   end

   function automatic logic [7:0] exp_a(int c);
      logic [31:0] t;
      if (q_a.size() == 0) return 8'h5A;
      t = q_a[0];
      return t[8*c +: 8];
   endfunction

   function automatic logic [7:0] exp_b(int c);
      logic [31:0] t;
      if (q_b.size() == 0) return 8'h00;
      t = q_b[0];
      return t[8*c +: 8];
   endfunction

   task automatic set_a(input logic [31:0] e);
      for (int c = 0; c < C; c++) a_din[c] = e[8*c +: 8];
   endtask

   task automatic set_b(input logic [31:0] e);
      for (int c = 0; c < C; c++) b_din[c] = e[8*c +: 8];
   endtask

   function automatic logic [31:0] pat(int i);
      logic [31:0] e;
      for (int c = 0; c < C; c++) e[8*c +: 8] = 8'(10 * i + c);
      return e;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      set_a(32'h0); set_b(32'h0);
      #2 rst_n = 1'b0;
      q_a.delete(); q_b.delete(); ov_b = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         n_cmp++;
         if (a_count !== 3'd0 || a_empty !== 1'b1 || a_in_ready !== 1'b1 || a_full !== 1'b0 || a_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags_a cyc %0d: count=%0d empty=%b in_ready=%b full=%b out_valid=%b, want 0 1 1 0 0",
                     k, a_count, a_empty, a_in_ready, a_full, a_out_valid);
         end
         n_cmp++;
         if (b_overrun !== 1'b0 || b_in_ready !== 1'b1 || b_empty !== 1'b1) begin
            n_err++;
            $display("FAIL reset_flags_b cyc %0d: overrun=%b in_ready=%b empty=%b, want 0 1 1", k, b_overrun, b_in_ready, b_empty);
         end
         for (int c = 0; c < C; c++) begin
            n_cmp++;
            if (a_dout[c] !== 8'sh5A || b_dout[c] !== 8'sh00) begin
               n_err++;
               $display("FAIL reset_dout ch%0d: a=%h b=%h, want 5a 00", c, a_dout[c], b_dout[c]);
            end
         end
      end
   endtask

   task automatic test_fill_drain();
      a_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_a(pat(i)); a_in_valid = 1'b1;
         @(negedge clk);
      end
      set_a(32'h63636363);
      n_cmp++;
      if (a_full !== 1'b1 || a_in_ready !== 1'b0 || a_count !== 3'd4) begin
         n_err++;
         $display("FAIL fill_full: full=%b in_ready=%b count=%0d, want 1 0 4", a_full, a_in_ready, a_count);
      end
      @(negedge clk);
      a_in_valid = 1'b0;
      n_cmp++;
      if (a_count !== 3'd4 || a_dout[0] !== 8'sd0) begin
         n_err++;
         $display("FAIL fifth_push_ignored: count=%0d head0=%0d, want 4 0", a_count, a_dout[0]);
      end
      a_out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (a_count !== 3'(4 - i)) begin
            n_err++;
            $display("FAIL drain_count pop %0d: count=%0d, want %0d", i, a_count, 4 - i);
         end
         for (int c = 0; c < C; c++) begin
            n_cmp++;
            if (int'(a_dout[c]) !== 10 * i + c) begin
               n_err++;
               $display("FAIL drain_order pop %0d ch%0d: got %0d, want %0d", i, c, a_dout[c], 10 * i + c);
            end
         end
         @(negedge clk);
      end
      a_out_ready = 1'b0;
      n_cmp++;
      if (a_count !== 3'd0 || a_empty !== 1'b1 || a_dout[0] !== 8'sh5A) begin
         n_err++;
         $display("FAIL drain_empty: count=%0d empty=%b dout0=%h, want 0 1 5a", a_count, a_empty, a_dout[0]);
      end
   endtask

   task automatic test_stream();
      a_out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         set_a($urandom); a_in_valid = 1'b1;
         @(negedge clk);
      end
      a_out_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
         set_a($urandom);
         @(negedge clk);
         n_cmp++;
         if (a_count !== 3'd2 || a_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stream_count cyc %0d: count=%0d in_ready=%b, want 2 1", k, a_count, a_in_ready);
         end
         for (int c = 0; c < C; c++) begin
            n_cmp++;
            if (a_dout[c] !== exp_a(c)) begin
               n_err++;
               $display("FAIL stream_order cyc %0d ch%0d: got %h, want %h", k, c, a_dout[c], exp_a(c));
            end
         end
      end
      a_in_valid = 1'b0;
      repeat (2) @(negedge clk);
      a_out_ready = 1'b0;
      n_cmp++;
      if (a_empty !== 1'b1) begin
         n_err++;
         $display("FAIL stream_drain: empty=%b, want 1", a_empty);
      end
   endtask

   task automatic test_overwrite();
      b_out_ready = 1'b0;
      for (int v = 1; v <= 6; v++) begin
         set_b({4{8'(v)}}); b_in_valid = 1'b1;
         @(negedge clk);
      end
      b_in_valid = 1'b0;
      n_cmp++;
      if (b_overrun !== 1'b1 || b_count !== 3'd4 || b_full !== 1'b1) begin
         n_err++;
         $display("FAIL ovw_flags: overrun=%b count=%0d full=%b, want 1 4 1", b_overrun, b_count, b_full);
      end
      b_out_ready = 1'b1;
      for (int v = 3; v <= 6; v++) begin
         for (int c = 0; c < C; c++) begin
            n_cmp++;
            if (int'(b_dout[c]) !== v) begin
               n_err++;
               $display("FAIL ovw_pop ch%0d: got %0d, want %0d", c, b_dout[c], v);
            end
         end
         @(negedge clk);
      end
      b_out_ready = 1'b0;
      n_cmp++;
      if (b_empty !== 1'b1 || b_overrun !== 1'b1) begin
         n_err++;
         $display("FAIL ovw_sticky: empty=%b overrun=%b, want 1 1", b_empty, b_overrun);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) begin
         set_a(pat(i + 5)); a_in_valid = 1'b1;
         @(negedge clk);
      end
      a_flush = 1'b1; b_flush = 1'b1; b_in_valid = 1'b1; set_b(32'h11223344);
      set_a(32'h77777777);
      @(negedge clk);
      a_flush = 1'b0; b_flush = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
      n_cmp++;
      if (a_count !== 3'd0 || a_empty !== 1'b1 || a_in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL flush_a: count=%0d empty=%b in_ready=%b, want 0 1 1", a_count, a_empty, a_in_ready);
      end
      n_cmp++;
      if (b_count !== 3'd0 || b_overrun !== 1'b0 || b_empty !== 1'b1) begin
         n_err++;
         $display("FAIL flush_b: count=%0d overrun=%b empty=%b, want 0 0 1", b_count, b_overrun, b_empty);
      end
      for (int c = 0; c < C; c++) begin
         n_cmp++;
         if (a_dout[c] !== 8'sh5A) begin
            n_err++;
            $display("FAIL flush_dout ch%0d: got %h, want 5a", c, a_dout[c]);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         set_a(pat(i + 1)); set_b(pat(i + 2));
         a_in_valid = 1'b1; b_in_valid = 1'b1;
         @(negedge clk);
      end
      a_out_ready = 1'b1; b_out_ready = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      q_a.delete(); q_b.delete(); ov_b = 1'b0;
      #1;
      n_cmp++;
      if (a_count !== 3'd0 || a_empty !== 1'b1 || a_out_valid !== 1'b0 || a_in_ready !== 1'b1 ||
          b_count !== 3'd0 || b_overrun !== 1'b0 || a_dout[1] !== 8'sh5A || b_dout[1] !== 8'sh00) begin
         n_err++;
         $display("FAIL async_reset: a_count=%0d a_empty=%b a_ov=%b a_rdy=%b b_count=%0d b_ovr=%b a_d1=%h b_d1=%h",
                  a_count, a_empty, a_out_valid, a_in_ready, b_count, b_overrun, a_dout[1], b_dout[1]);
      end
      repeat (2) @(negedge clk);
      n_cmp++;
      if (a_count !== 3'd0 || b_count !== 3'd0) begin
         n_err++;
         $display("FAIL reset_hold: a_count=%0d b_count=%0d, want 0 0", a_count, b_count);
      end
      a_in_valid = 1'b0; b_in_valid = 1'b0; a_out_ready = 1'b0; b_out_ready = 1'b0;
      rst_n = 1'b1;
      set_a(32'h01FF7F80); a_in_valid = 1'b1;
      @(negedge clk);
      set_a(32'hFF01807F);
      @(negedge clk);
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      n_cmp++;
      if (int'(a_dout[0]) !== -128 || int'(a_dout[1]) !== 127 || int'(a_dout[2]) !== -1 || int'(a_dout[3]) !== 1) begin
         n_err++;
         $display("FAIL signed_rt0: got %0d %0d %0d %0d, want -128 127 -1 1", a_dout[0], a_dout[1], a_dout[2], a_dout[3]);
      end
      @(negedge clk);
      n_cmp++;
      if (int'(a_dout[0]) !== 127 || int'(a_dout[1]) !== -128 || int'(a_dout[2]) !== 1 || int'(a_dout[3]) !== -1) begin
         n_err++;
         $display("FAIL signed_rt1: got %0d %0d %0d %0d, want 127 -128 1 -1", a_dout[0], a_dout[1], a_dout[2], a_dout[3]);
      end
      @(negedge clk);
      a_out_ready = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         a_in_valid = ($urandom_range(0, 9) < 6);
         a_out_ready = ($urandom_range(0, 9) < 5);
         a_flush = ($urandom_range(0, 31) == 0);
         b_in_valid = ($urandom_range(0, 9) < 6);
         b_out_ready = ($urandom_range(0, 9) < 4);
         b_flush = ($urandom_range(0, 63) == 0);
         set_a($urandom); set_b($urandom);
         @(negedge clk);
         n_cmp++;
         if (a_count !== 3'(q_a.size()) || a_full !== (q_a.size() == D) || a_empty !== (q_a.size() == 0) ||
             a_in_ready !== (q_a.size() < D) || a_out_valid !== (q_a.size() != 0)) begin
            n_err++;
            $display("FAIL rand_flags_a cyc %0d: count=%0d full=%b empty=%b in_ready=%b out_valid=%b, want count %0d",
                     k, a_count, a_full, a_empty, a_in_ready, a_out_valid, q_a.size());
         end
         n_cmp++;
         if (b_count !== 3'(q_b.size()) || b_full !== (q_b.size() == D) || b_empty !== (q_b.size() == 0) ||
             b_in_ready !== 1'b1 || b_overrun !== ov_b) begin
            n_err++;
            $display("FAIL rand_flags_b cyc %0d: count=%0d full=%b empty=%b in_ready=%b overrun=%b, want count %0d overrun %b",
                     k, b_count, b_full, b_empty, b_in_ready, b_overrun, q_b.size(), ov_b);
         end
         for (int c = 0; c < C; c++) begin
            n_cmp++;
            if (a_dout[c] !== exp_a(c) || b_dout[c] !== exp_b(c)) begin
               n_err++;
               $display("FAIL rand_data cyc %0d ch%0d: a=%h b=%h, want %h %h", k, c, a_dout[c], b_dout[c], exp_a(c), exp_b(c));
            end
         end
      end
      a_in_valid = 1'b0; b_in_valid = 1'b0; a_flush = 1'b0; b_flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_stream();
      test_overwrite();
      test_flush();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
